// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response bundle between the two memory clients
// (instruction cache and load/store buffer) and mem_ctrl.
//
// Signals
//   ic_ask     Icache fetch request, held until ic_valid is seen
//   ic_addr    fetch address (word aligned)
//   ic_valid   one-cycle fetch completion pulse
//   ic_inst    fetched word
//   lsb_req    LSB request, held until lsb_done is seen
//   lsb_wr     1 = store
//   lsb_len    00 byte, 01 half, 10 word (11 behaves as word)
//   lsb_addr   byte address
//   lsb_wdata  store data, low n bytes used
//   lsb_done   one-cycle completion pulse
//   lsb_rdata  load data, zero-extended
//
// Modports
//   master  the requesting side (Icache + LSB)
//   slave   the memory controller
interface mem_ctrl_if;
    logic        ic_ask;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_inst;

    logic        lsb_req;
    logic        lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    modport master (
        output ic_ask, ic_addr,
        output lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
        input  ic_valid, ic_inst,
        input  lsb_done, lsb_rdata
    );

    modport slave (
        input  ic_ask, ic_addr,
        input  lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
        output ic_valid, ic_inst,
        output lsb_done, lsb_rdata
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: sole owner of the byte-wide RAM/IO port. Arbitrates between the
// instruction cache and the load/store buffer, serializes each access into
// single-byte RAM cycles and returns one completion pulse per transaction.
//
// Parameters
//   RR_ENABLE       1 = round-robin on simultaneous requests, 0 = LSB wins
//
// Ports
//   clk_in          clock, rising edge
//   rst_in          synchronous reset, active low
//   rdy_in          global enable; 0 freezes every register
//   clear_in        pipeline flush; aborts an in-flight Icache read
//   mem_din         RAM read byte (valid two edges after its address)
//   mem_dout        RAM write byte
//   mem_a           RAM/IO byte address
//   mem_wr          1 = write cycle
//   io_buffer_full  UART buffer full; holds back IO stores
//   bus             client request/response bundle (slave side)
module mem_ctrl #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    mem_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IC  = 1'b0,
        OWN_LSB = 1'b1
    } owner_e;

    // Every register of the controller lives in this bundle, so the freeze
    // on rdy_in and the reset each come down to a single statement.
    typedef struct packed {
        state_e      state;
        owner_e      owner;
        owner_e      last_grant;
        logic [31:0] base;
        logic [2:0]  n;         // total bytes: 1, 2 or 4
        logic [2:0]  issue;     // bytes whose address has been driven
        logic [2:0]  got;       // bytes captured from mem_din
        logic        warm;      // set once the first read byte is in flight
        logic [31:0] data_buf;
        logic [31:0] wdata;
        logic [31:0] mem_a;
        logic [7:0]  mem_dout;
        logic        mem_wr;
        logic        ic_valid;
        logic [31:0] ic_inst;
        logic        lsb_done;
        logic [31:0] lsb_rdata;
    } ctrl_t;

    ctrl_t cur;
    ctrl_t nxt;

    logic        lsb_io_blocked;
    logic        ic_elig;
    logic        lsb_elig;
    logic        grant_ic;
    logic        grant_lsb;
    logic [2:0]  lsb_n;
    logic [31:0] cap_buf;

    // Arbitration. An IO store (address bits 17:16 = 11) cannot start while
    // the UART buffer is full; the Icache may take the port meanwhile.
    always_comb begin
        lsb_io_blocked = bus.lsb_wr && (bus.lsb_addr[17:16] == 2'b11) && io_buffer_full;
        ic_elig        = bus.ic_ask;
        lsb_elig       = bus.lsb_req && !lsb_io_blocked;
        grant_lsb      = lsb_elig && (!ic_elig || !RR_ENABLE || (cur.last_grant == OWN_IC));
        grant_ic       = ic_elig && !grant_lsb;

        case (bus.lsb_len)
            2'b00:   lsb_n = 3'd1;
            2'b01:   lsb_n = 3'd2;
            default: lsb_n = 3'd4;
        endcase
    end

    // Read buffer with the incoming byte merged in little-endian position.
    always_comb begin
        cap_buf = cur.data_buf;
        cap_buf[{cur.got[1:0], 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        // NOTE: start from the current register image so every field has a
        // value on every path; nothing here can turn into a latch.
        nxt          = cur;
        nxt.ic_valid = 1'b0;
        nxt.lsb_done = 1'b0;

        case (cur.state)
            IDLE: begin
                if (grant_ic || grant_lsb) begin
                    nxt.owner      = grant_ic ? OWN_IC : OWN_LSB;
                    nxt.last_grant = grant_ic ? OWN_IC : OWN_LSB;
                    nxt.base       = grant_ic ? bus.ic_addr : bus.lsb_addr;
                    nxt.n          = grant_ic ? 3'd4 : lsb_n;
                    nxt.wdata      = bus.lsb_wdata;
                    nxt.issue      = 3'd1;
                    nxt.got        = 3'd0;
                    nxt.warm       = 1'b0;
                    nxt.data_buf   = '0;
                    nxt.mem_a      = grant_ic ? bus.ic_addr : bus.lsb_addr;
                    if (grant_lsb && bus.lsb_wr) begin
                        nxt.state    = WRITE;
                        nxt.mem_dout = bus.lsb_wdata[7:0];
                        nxt.mem_wr   = 1'b1;
                    end else begin
                        nxt.state    = READ;
                    end
                end
            end

            READ: begin
                nxt.mem_wr = 1'b0;
                if (clear_in && (cur.owner == OWN_IC)) begin
                    // Flushed fetch: drop it silently, bytes in flight are ignored.
                    nxt.state = IDLE;
                end else begin
                    if (cur.issue < cur.n) begin
                        nxt.mem_a = cur.base + {29'd0, cur.issue};
                        nxt.issue = cur.issue + 3'd1;
                    end
                    // RAM data trails its address by two edges: the first
                    // READ edge only arms capture, later edges take a byte.
                    if (!cur.warm) begin
                        nxt.warm = 1'b1;
                    end else begin
                        nxt.data_buf = cap_buf;
                        nxt.got      = cur.got + 3'd1;
                        if ((cur.got + 3'd1) == cur.n) begin
                            nxt.state = DONE;
                            if (cur.owner == OWN_IC) begin
                                nxt.ic_inst  = cap_buf;
                                nxt.ic_valid = 1'b1;
                            end else begin
                                nxt.lsb_rdata = cap_buf;
                                nxt.lsb_done  = 1'b1;
                            end
                        end
                    end
                end
            end

            WRITE: begin
                if (cur.issue < cur.n) begin
                    nxt.mem_a    = cur.base + {29'd0, cur.issue};
                    nxt.mem_dout = cur.wdata[{cur.issue[1:0], 3'b000} +: 8];
                    nxt.mem_wr   = 1'b1;
                    nxt.issue    = cur.issue + 3'd1;
                end else begin
                    nxt.mem_wr   = 1'b0;
                    nxt.lsb_done = 1'b1;
                    nxt.state    = DONE;
                end
            end

            // Requester is still lowering its request during this cycle.
            DONE: nxt.state = IDLE;

            default: nxt.state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: the whole bundle, read buffer included, is cleared; the
        // all-zero image encodes IDLE with last_grant = IC.
        if (!rst_in) begin
            cur <= '0;
        end else if (rdy_in) begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            cur <= nxt;
        end
    end

    assign mem_a         = cur.mem_a;
    assign mem_dout      = cur.mem_dout;
    assign mem_wr        = cur.mem_wr;
    assign bus.ic_valid  = cur.ic_valid;
    assign bus.ic_inst   = cur.ic_inst;
    assign bus.lsb_done  = cur.lsb_done;
    assign bus.lsb_rdata = cur.lsb_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl. Expected completions (owner,
// data, edge) are queued when a request is issued; a monitor pops and
// compares on every ic_valid / lsb_done pulse. A second instance with
// RR_ENABLE = 0 sees permanently held requests to show fixed LSB priority.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        io_buffer_full;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  fp_mem_dout;
    logic [31:0] fp_mem_a;
    logic        fp_mem_wr;
    logic        fp_en;

    mem_ctrl_if bus();
    mem_ctrl_if bus_fp();

    mem_ctrl #(.RR_ENABLE(1'b1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .bus(bus)
    );

    mem_ctrl #(.RR_ENABLE(1'b0)) dut_fp (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .mem_din(mem_din), .mem_dout(fp_mem_dout), .mem_a(fp_mem_a), .mem_wr(fp_mem_wr),
        .io_buffer_full(io_buffer_full), .bus(bus_fp)
    );

    assign bus_fp.ic_ask    = fp_en;
    assign bus_fp.ic_addr   = 32'h0000_1000;
    assign bus_fp.lsb_req   = fp_en;
    assign bus_fp.lsb_wr    = 1'b0;
    assign bus_fp.lsb_len   = 2'b00;
    assign bus_fp.lsb_addr  = 32'h0000_2003;
    assign bus_fp.lsb_wdata = 32'h0;

    always #5 clk_in = ~clk_in;

    int edge_cnt = 0;
    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    // Byte RAM on the same enable as the controller; IO stores go to a log.
    logic [7:0] ram [0:65535];
    logic [7:0] io_log [$];
    always @(posedge clk_in) begin
        if (rdy_in) begin
            mem_din <= ram[mem_a[15:0]];
            if (mem_wr) begin
                if (mem_a[17:16] == 2'b11) io_log.push_back(mem_dout);
                else ram[mem_a[15:0]] = mem_dout;
            end
        end
    end

    typedef struct {
        logic [7:0]  who;       // "I" or "L"
        logic [31:0] data;
        bit          chk_data;
        int          at_edge;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   hold_req = 1'b0;
    int   fp_lo = 1, fp_hi = 0;
    int   fp_ic_cnt = 0, fp_lsb_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic take_pulse(input string nm, input logic [7:0] who, input logic [31:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_pulse: got a pulse at edge %0d, expected none", nm, edge_cnt);
        end else begin
            e = sb.pop_front();
            check({nm, "_owner"}, 32'(who), 32'(e.who));
            check({nm, "_edge"}, 32'(edge_cnt), 32'(e.at_edge));
            if (e.chk_data) check({nm, "_data"}, data, e.data);
        end
    endtask

    // Monitor + requester behaviour: a request is lowered once its pulse is seen.
    always @(negedge clk_in) begin
        if (bus.ic_valid)  take_pulse("ic", 8'h49, bus.ic_inst);
        if (bus.lsb_done)  take_pulse("lsb", 8'h4C, bus.lsb_rdata);
        if (!hold_req) begin
            if (bus.ic_valid) bus.ic_ask  = 1'b0;
            if (bus.lsb_done) bus.lsb_req = 1'b0;
        end
        if (edge_cnt >= fp_lo && edge_cnt <= fp_hi) begin
            if (bus_fp.ic_valid) fp_ic_cnt++;
            if (bus_fp.lsb_done) fp_lsb_cnt++;
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk_in);
    endtask

    task automatic push_exp(input logic [7:0] who, input logic [31:0] data, input bit chk, input int at);
        exp_t e;
        e.who = who; e.data = data; e.chk_data = chk; e.at_edge = at;
        sb.push_back(e);
    endtask

    task automatic ic_start(input logic [31:0] addr);
        bus.ic_ask  = 1'b1;
        bus.ic_addr = addr;
    endtask

    task automatic lsb_start(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                             input logic [31:0] wd);
        bus.lsb_req   = 1'b1;
        bus.lsb_wr    = wr;
        bus.lsb_len   = len;
        bus.lsb_addr  = addr;
        bus.lsb_wdata = wd;
    endtask

    initial begin
        int c;
        logic [31:0] a;
        logic [31:0] wd;

        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0; fp_en = 1'b0;
        bus.ic_ask = 1'b0; bus.ic_addr = 32'h0;
        bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_len = 2'b00;
        bus.lsb_addr = 32'h0; bus.lsb_wdata = 32'h0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h10; ram[16'h1003] = 8'h00;
        ram[16'h1004] = 8'h78; ram[16'h1005] = 8'h56; ram[16'h1006] = 8'h34; ram[16'h1007] = 8'h12;
        ram[16'h2003] = 8'hFF; ram[16'h2004] = 8'h80;
        ram[16'hFFFE] = 8'h11; ram[16'hFFFF] = 8'h22; ram[16'h0000] = 8'h33; ram[16'h0001] = 8'h44;

        // Reset state
        step(3);
        rst_in = 1'b1;
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_ic_valid", 32'(bus.ic_valid), 32'h0);
        check("rst_lsb_done", 32'(bus.lsb_done), 32'h0);
        check("rst_ic_inst", bus.ic_inst, 32'h0);
        check("rst_lsb_rdata", bus.lsb_rdata, 32'h0);

        // Icache word fetch at 0x1000: pulse after E5
        c = edge_cnt;
        ic_start(32'h1000);
        push_exp(8'h49, 32'h00100513, 1'b1, c + 6);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("ic_rd_addr", mem_a, 32'h1000 + 32'(i));
            check("ic_rd_wr", 32'(mem_wr), 32'h0);
        end
        step(4);
        check("ic_inst_hold", bus.ic_inst, 32'h00100513);

        // Half load at 0x2003: pulse after E3
        c = edge_cnt;
        lsb_start(1'b0, 2'b01, 32'h2003, 32'h0);
        push_exp(8'h4C, 32'h000080FF, 1'b1, c + 4);
        step(5);

        // Word load at 0xFFFFFFFE: address wraps to 0, 1
        c = edge_cnt;
        lsb_start(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0);
        push_exp(8'h4C, 32'h44332211, 1'b1, c + 6);
        for (int i = 0; i < 4; i++) begin
            step(1);
            a = 32'hFFFF_FFFE + 32'(i);
            check("wrap_addr", mem_a, a);
        end
        step(3);

        // Word store 0xDEADBEEF to 0x3000
        c = edge_cnt;
        wd = 32'hDEADBEEF;
        lsb_start(1'b1, 2'b10, 32'h3000, wd);
        push_exp(8'h4C, 32'h0, 1'b0, c + 5);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("st_addr", mem_a, 32'h3000 + 32'(i));
            check("st_dout", 32'(mem_dout), 32'(wd[8*i +: 8]));
            check("st_wr", 32'(mem_wr), 32'h1);
        end
        step(1);
        check("st_wr_end", 32'(mem_wr), 32'h0);
        step(1);
        check("st_ram", {ram[16'h3003], ram[16'h3002], ram[16'h3001], ram[16'h3000]}, 32'hDEADBEEF);

        // IO store held by a full UART buffer; concurrent fetch goes first
        c = edge_cnt;
        io_buffer_full = 1'b1;
        lsb_start(1'b1, 2'b00, 32'h0003_0000, 32'h0000_005A);
        ic_start(32'h1000);
        push_exp(8'h49, 32'h00100513, 1'b1, c + 6);
        push_exp(8'h4C, 32'h0, 1'b0, c + 11);
        step(8);
        check("io_held_wr_a", 32'(mem_wr), 32'h0);
        step(1);
        check("io_held_wr_b", 32'(mem_wr), 32'h0);
        io_buffer_full = 1'b0;
        step(1);
        check("io_addr", mem_a, 32'h0003_0000);
        check("io_dout", 32'(mem_dout), 32'h5A);
        check("io_wr", 32'(mem_wr), 32'h1);
        step(2);
        check("io_log_cnt", 32'(io_log.size()), 32'h1);
        if (io_log.size() > 0) check("io_log_byte", 32'(io_log[0]), 32'h5A);

        // Round robin with both requests held; fixed-priority copy alongside
        rst_in = 1'b0;
        step(2);
        rst_in = 1'b1;
        c = edge_cnt;
        hold_req = 1'b1;
        fp_en = 1'b1;
        fp_lo = c + 1;
        fp_hi = c + 20;
        ic_start(32'h1000);
        lsb_start(1'b0, 2'b00, 32'h2003, 32'h0);
        push_exp(8'h4C, 32'h000000FF, 1'b1, c + 3);
        push_exp(8'h49, 32'h00100513, 1'b1, c + 10);
        push_exp(8'h4C, 32'h000000FF, 1'b1, c + 14);
        step(14);
        bus.ic_ask = 1'b0;
        bus.lsb_req = 1'b0;
        hold_req = 1'b0;
        step(6);
        fp_en = 1'b0;
        check("fp_lsb_grants", 32'(fp_lsb_cnt), 32'd5);
        check("fp_ic_grants", 32'(fp_ic_cnt), 32'd0);
        step(2);

        // Flush at E2 of a fetch: no ic_valid, IDLE after E2
        c = edge_cnt;
        ic_start(32'h1000);
        step(2);
        clear_in = 1'b1;
        bus.ic_ask = 1'b0;
        step(1);
        clear_in = 1'b0;
        check("clr_wr", 32'(mem_wr), 32'h0);
        lsb_start(1'b0, 2'b00, 32'h2004, 32'h0);
        push_exp(8'h4C, 32'h00000080, 1'b1, c + 6);
        step(4);
        check("clr_ic_inst_kept", bus.ic_inst, 32'h00100513);

        // Flush during a store does not abort it
        c = edge_cnt;
        clear_in = 1'b1;
        lsb_start(1'b1, 2'b10, 32'h3010, 32'h01020304);
        push_exp(8'h4C, 32'h0, 1'b0, c + 5);
        step(3);
        clear_in = 1'b0;
        step(3);
        check("clr_st_ram", {ram[16'h3013], ram[16'h3012], ram[16'h3011], ram[16'h3010]}, 32'h01020304);

        // Three-cycle freeze mid-fetch: completion moves by exactly three edges
        c = edge_cnt;
        ic_start(32'h1004);
        push_exp(8'h49, 32'h12345678, 1'b1, c + 9);
        step(2);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("frz_addr", mem_a, 32'h1005);
            step(1);
        end
        rdy_in = 1'b1;
        check("frz_addr_end", mem_a, 32'h1005);
        step(5);

        // Reset in the middle of a store: everything zero, no pulse
        c = edge_cnt;
        lsb_start(1'b1, 2'b10, 32'h3020, 32'hCAFEBABE);
        step(2);
        rst_in = 1'b0;
        bus.lsb_req = 1'b0;
        step(1);
        check("mrst_mem_wr", 32'(mem_wr), 32'h0);
        check("mrst_mem_a", mem_a, 32'h0);
        check("mrst_mem_dout", 32'(mem_dout), 32'h0);
        check("mrst_lsb_done", 32'(bus.lsb_done), 32'h0);
        check("mrst_ic_inst", bus.ic_inst, 32'h0);
        check("mrst_lsb_rdata", bus.lsb_rdata, 32'h0);
        rst_in = 1'b1;
        step(6);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
